// File: rtl/conv_stream.sv
// conv_stream: streaming 1-D valid convolution.
//   Loads an N-sample x vector and an M-tap filter f over two independent
//   valid/ready channels, then emits y[i] = sum_j x[i+j]*f[j] for
//   i = 0..N-M, one result per handshake, saturated to OW bits
//   (optionally clamped at 0 when RELU=1).
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   s_data_in_x/s_valid_x/s_ready_x   x sample channel
//   s_data_in_f/s_valid_f/s_ready_f   filter coefficient channel
//   m_data_out_y/m_valid_y/m_ready_y  result channel
module conv_stream #(
    parameter int N    = 8,
    parameter int M    = 4,
    parameter int DW   = 8,
    parameter int OW   = 18,
    parameter int RELU = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] s_data_in_x,
    input  logic                 s_valid_x,
    output logic                 s_ready_x,
    input  logic signed [DW-1:0] s_data_in_f,
    input  logic                 s_valid_f,
    output logic                 s_ready_f,
    output logic signed [OW-1:0] m_data_out_y,
    output logic                 m_valid_y,
    input  logic                 m_ready_y
);

    localparam int XAW = (N > 1) ? $clog2(N) : 1;
    localparam int FAW = $clog2(M);
    localparam int XCW = $clog2(N + 1);
    localparam int FCW = $clog2(M + 1);
    localparam int STW = $clog2(M + 2);
    localparam int PW  = 2 * DW;
    localparam int AW  = 2 * DW + $clog2(M);
    localparam int CW  = ((AW > OW) ? AW : OW) + 1;

    localparam logic [XCW-1:0] N_C   = XCW'(N);
    localparam logic [FCW-1:0] M_CNT = FCW'(M);
    localparam logic [STW-1:0] M_ST  = STW'(M);
    localparam logic [STW-1:0] M1_ST = STW'(M + 1);
    localparam logic [XAW-1:0] LAST  = XAW'(N - M);

    localparam logic [CW-1:0]        ONE  = 1;
    localparam logic signed [CW-1:0] OMAX = $signed((ONE << (OW - 1)) - ONE);
    localparam logic signed [CW-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

    state_t                 state;
    logic [XCW-1:0]         x_cnt;
    logic [FCW-1:0]         f_cnt;
    logic [XAW-1:0]         base;
    logic [STW-1:0]         step;
    logic signed [AW-1:0]   acc;

    logic signed [DW-1:0]   x_mem [N];
    logic signed [DW-1:0]   f_mem [M];
    logic signed [DW-1:0]   rd_x;
    logic signed [DW-1:0]   rd_f;
    logic [XAW-1:0]         x_raddr;
    logic [FAW-1:0]         f_raddr;
    logic                   rd_en;

    logic signed [PW-1:0]   prod;
    logic signed [AW-1:0]   prod_ext;
    logic signed [CW-1:0]   acc_ext;
    logic signed [OW-1:0]   sat_val;

    // Ready is gated by reset so both channels read 0 while reset is held
    // and rise as soon as it is released.
    assign s_ready_x = !reset && (state == LOAD) && (x_cnt < N_C);
    assign s_ready_f = !reset && (state == LOAD) && (f_cnt < M_CNT);

    // COMPUTE steps 0..M-1 issue reads; data arrives one cycle later.
    assign rd_en   = (state == COMPUTE) && (step < M_ST);
    assign x_raddr = base + XAW'(step);
    assign f_raddr = FAW'(step);

    always_ff @(posedge clk) begin
        if (s_valid_x && s_ready_x)
            x_mem[x_cnt[XAW-1:0]] <= s_data_in_x;
        if (s_valid_f && s_ready_f)
            f_mem[f_cnt[FAW-1:0]] <= s_data_in_f;
        if (rd_en) begin
            rd_x <= x_mem[x_raddr];
            rd_f <= f_mem[f_raddr];
        end
    end

    assign prod     = PW'(rd_x) * PW'(rd_f);
    assign prod_ext = {{(AW - PW){prod[PW-1]}}, prod};
    assign acc_ext  = {{(CW - AW){acc[AW-1]}}, acc};

    always_comb begin
        sat_val = acc_ext[OW-1:0];
        if (acc_ext > OMAX)
            sat_val = OMAX[OW-1:0];
        else if (acc_ext < OMIN)
            sat_val = OMIN[OW-1:0];
        if ((RELU != 0) && sat_val[OW-1])
            sat_val = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LOAD;
            x_cnt        <= '0;
            f_cnt        <= '0;
            base         <= '0;
            step         <= '0;
            acc          <= '0;
            m_valid_y    <= 1'b0;
            m_data_out_y <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (s_valid_x && s_ready_x)
                        x_cnt <= x_cnt + 1'b1;
                    if (s_valid_f && s_ready_f)
                        f_cnt <= f_cnt + 1'b1;
                    if ((x_cnt == N_C) && (f_cnt == M_CNT)) begin
                        state <= COMPUTE;
                        step  <= '0;
                        acc   <= '0;
                    end
                end
                COMPUTE: begin
                    step <= step + 1'b1;
                    // Steps 1..M consume the read issued on the previous step.
                    if ((step != '0) && (step <= M_ST))
                        acc <= acc + prod_ext;
                    if (step == M1_ST) begin
                        m_data_out_y <= sat_val;
                        m_valid_y    <= 1'b1;
                        state        <= OUTPUT;
                        step         <= '0;
                    end
                end
                OUTPUT: begin
                    if (m_ready_y) begin
                        m_valid_y <= 1'b0;
                        acc       <= '0;
                        if (base == LAST) begin
                            state <= LOAD;
                            x_cnt <= '0;
                            f_cnt <= '0;
                            base  <= '0;
                        end else begin
                            base  <= base + 1'b1;
                            state <= COMPUTE;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_stream.sv
// Directed bench for conv_stream. Three instances share clk/reset:
//   0: defaults, 1: RELU=1, 2: OW=12 (saturation).
module tb_conv_stream;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] sx [3];
    logic [7:0] sf [3];
    logic vx [3];
    logic vf [3];
    logic rx [3];
    logic rf [3];
    logic mr [3];
    logic mv [3];
    logic signed [17:0] y0;
    logic signed [17:0] y1;
    logic signed [11:0] y2;

    int checks = 0;
    int errors = 0;
    int xa [8];
    int fa [4];
    int ea [5];

    always #5 clk = ~clk;

    conv_stream u0 (
        .clk(clk), .reset(reset),
        .s_data_in_x(sx[0]), .s_valid_x(vx[0]), .s_ready_x(rx[0]),
        .s_data_in_f(sf[0]), .s_valid_f(vf[0]), .s_ready_f(rf[0]),
        .m_data_out_y(y0), .m_valid_y(mv[0]), .m_ready_y(mr[0])
    );

    conv_stream #(.RELU(1)) u1 (
        .clk(clk), .reset(reset),
        .s_data_in_x(sx[1]), .s_valid_x(vx[1]), .s_ready_x(rx[1]),
        .s_data_in_f(sf[1]), .s_valid_f(vf[1]), .s_ready_f(rf[1]),
        .m_data_out_y(y1), .m_valid_y(mv[1]), .m_ready_y(mr[1])
    );

    conv_stream #(.OW(12)) u2 (
        .clk(clk), .reset(reset),
        .s_data_in_x(sx[2]), .s_valid_x(vx[2]), .s_ready_x(rx[2]),
        .s_data_in_f(sf[2]), .s_valid_f(vf[2]), .s_ready_f(rf[2]),
        .m_data_out_y(y2), .m_valid_y(mv[2]), .m_ready_y(mr[2])
    );

    function automatic logic signed [31:0] yv(input int k);
        if (k == 0) return 32'(y0);
        if (k == 1) return 32'(y1);
        return 32'(y2);
    endfunction

    task automatic set_vec_a();
        xa = '{10, -20, 30, -40, 50, 60, 70, 80};
        fa = '{10, 20, -30, 40};
        ea = '{-2800, 3600, 400, 1600, 2800};
    endtask

    task automatic set_vec_b();
        xa = '{-90, 100, -110, 120, -50, 40, 30, -20};
        fa = '{-50, -60, 70, 80};
        ea = '{400, 6000, -2000, 2200, 600};
    endtask

    // Feeds xa/fa; with rnd, valids toggle randomly and garbage is offered
    // on a channel that is already full (ready must stay 0 there).
    task automatic load_vec(input int k, input bit rnd);
        int xi = 0;
        int fi = 0;
        int cyc = 0;
        bit ax;
        bit af;
        while ((xi < 8 || fi < 4) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (mv[k] !== 1'b0) begin
                errors++;
                $display("FAIL load_no_valid inst%0d got m_valid=%b want 0", k, mv[k]);
            end
            ax = rnd ? ($urandom_range(0, 1) == 1) : (xi < 8);
            af = rnd ? ($urandom_range(0, 1) == 1) : (fi < 4);
            vx[k] = ax;
            vf[k] = af;
            sx[k] = !ax ? 8'hxx : (xi < 8) ? xa[xi][7:0] : 8'h5a;
            sf[k] = !af ? 8'hxx : (fi < 4) ? fa[fi][7:0] : 8'ha5;
            if (ax && xi < 8 && rx[k] === 1'b1) xi++;
            if (af && fi < 4 && rf[k] === 1'b1) fi++;
        end
        @(negedge clk);
        vx[k] = 1'b0;
        vf[k] = 1'b0;
        sx[k] = 8'hxx;
        sf[k] = 8'hxx;
        if (xi < 8 || fi < 4) begin
            checks++;
            errors++;
            $display("FAIL load_timeout inst%0d loaded x=%0d f=%0d want 8 and 4", k, xi, fi);
        end
    endtask

    task automatic collect(input int k, input int n, input bit rnd, input int stall_at);
        int got = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        bit rdy;
        while (got < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (got == stall_at && !stalled && mv[k] === 1'b1) begin
                stalled = 1'b1;
                mr[k] = 1'b0;
                for (int s = 0; s < 20; s++) begin
                    @(negedge clk);
                    checks++;
                    if (mv[k] !== 1'b1 || yv(k) !== ea[got]) begin
                        errors++;
                        $display("FAIL stall_hold inst%0d cycle %0d got valid=%b y=%0d want valid=1 y=%0d",
                                 k, s, mv[k], yv(k), ea[got]);
                    end
                end
            end
            rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            mr[k] = rdy;
            if (mv[k] === 1'b1 && rdy) begin
                checks++;
                if (yv(k) !== ea[got]) begin
                    errors++;
                    $display("FAIL y%0d inst%0d got %0d want %0d", got, k, yv(k), ea[got]);
                end
                got++;
            end
        end
        if (got < n) begin
            checks++;
            errors++;
            $display("FAIL collect_timeout inst%0d got %0d results want %0d", k, got, n);
        end
    endtask

    task automatic expect_idle(input int k, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            mr[k] = 1'b1;
            checks++;
            if (mv[k] !== 1'b0) begin
                errors++;
                $display("FAIL extra_result inst%0d cycle %0d got m_valid=%b want 0", k, c, mv[k]);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rx[k] !== 1'b0 || rf[k] !== 1'b0 || mv[k] !== 1'b0 || yv(k) !== 0) begin
                errors++;
                $display("FAIL %s inst%0d got rx=%b rf=%b mv=%b y=%0d want all 0",
                         tag, k, rx[k], rf[k], mv[k], yv(k));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rx[k] !== 1'b1 || rf[k] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_reset inst%0d got rx=%b rf=%b want 1 1", k, rx[k], rf[k]);
            end
        end
    endtask

    task automatic test_basic();
        set_vec_a();
        load_vec(0, 1'b0);
        collect(0, 5, 1'b0, -1);
        expect_idle(0, 100);
    endtask

    task automatic test_back_to_back();
        set_vec_b();
        load_vec(0, 1'b0);
        collect(0, 5, 1'b0, -1);
        expect_idle(0, 5);
    endtask

    task automatic test_random_stall();
        set_vec_a();
        load_vec(0, 1'b1);
        collect(0, 5, 1'b1, 2);
        expect_idle(0, 10);
    endtask

    task automatic test_reset_mid_compute();
        set_vec_a();
        load_vec(0, 1'b0);
        collect(0, 2, 1'b0, -1);
        // y1 is accepted on the next edge; the DUT then starts y2.
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_mid_compute");
        reset = 1'b0;
        expect_idle(0, 20);
        set_vec_b();
        load_vec(0, 1'b0);
        collect(0, 5, 1'b0, -1);
        expect_idle(0, 20);
    endtask

    task automatic test_relu();
        set_vec_a();
        ea = '{0, 3600, 400, 1600, 2800};
        load_vec(1, 1'b0);
        collect(1, 5, 1'b0, -1);
        expect_idle(1, 5);
    endtask

    task automatic test_saturation();
        xa = '{127, 127, 127, 127, 127, 127, 127, 127};
        fa = '{127, 127, 127, 127};
        ea = '{2047, 2047, 2047, 2047, 2047};
        load_vec(2, 1'b0);
        collect(2, 5, 1'b0, -1);
        xa = '{-128, -128, -128, -128, -128, -128, -128, -128};
        ea = '{-2048, -2048, -2048, -2048, -2048};
        load_vec(2, 1'b0);
        collect(2, 5, 1'b0, -1);
        expect_idle(2, 5);
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sx[k] = 8'h00;
            sf[k] = 8'h00;
            vx[k] = 1'b0;
            vf[k] = 1'b0;
            mr[k] = 1'b0;
        end
        test_reset();
        test_basic();
        test_back_to_back();
        test_random_stall();
        test_reset_mid_compute();
        test_relu();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_stream.md
CONV_STREAM -- requirements
Module: conv_stream

Interface
REQ-001 SHALL have parameter N, default 8, x vector length (N >= M).
REQ-002 SHALL have parameter M, default 4, filter length (M >= 2).
REQ-003 SHALL have parameter DW, default 8, signed input width.
REQ-004 SHALL have parameter OW, default 18, signed output width.
REQ-005 SHALL have parameter RELU, default 0; when 1, negative results output as 0.
REQ-006 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-007 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port s_data_in_x  in  DW  signed x sample.
REQ-009 SHALL have port s_valid_x  in  1  x sample valid.
REQ-010 SHALL have port s_ready_x  out  1  block accepts x.
REQ-011 SHALL have port s_data_in_f  in  DW  signed filter coefficient.
REQ-012 SHALL have port s_valid_f  in  1  f valid.
REQ-013 SHALL have port s_ready_f  out  1  block accepts f.
REQ-014 SHALL have port m_data_out_y  out  OW  signed result.
REQ-015 SHALL have port m_valid_y  out  1  result valid.
REQ-016 SHALL have port m_ready_y  in  1  consumer accepts result.

Function
REQ-017 SHALL transfer on a channel only on a rising edge with valid and ready both 1; data while valid=0 is ignored, including X.
REQ-018 SHALL store x into an N-entry memory and f into an M-entry memory, each with 1-cycle registered read latency.
REQ-019 SHALL use states LOAD, COMPUTE, OUTPUT; reset enters LOAD with both counts 0.
REQ-020 LOAD: s_ready_x=1 while x count < N; s_ready_f=1 while f count < M; channels load independently in any interleaving.
REQ-021 LOAD->COMPUTE the cycle after both memories are full; s_ready_x=s_ready_f=0 outside LOAD.
REQ-022 SHALL compute, for i=0..N-M, y[i] = sum over j=0..M-1 of x[i+j]*f[j], in order of i.
REQ-023 Product width 2*DW; accumulator width 2*DW+clog2(M); no intermediate overflow.
REQ-024 If accumulator exceeds OW range, output SHALL saturate to max or min OW signed value.
REQ-025 RELU=1: clamp negative values to 0 after saturation.
REQ-026 COMPUTE->OUTPUT with m_valid_y=1 no more than M+3 cycles after entering COMPUTE.
REQ-027 OUTPUT: m_data_out_y registered and stable while m_valid_y=1 and m_ready_y=0.
REQ-028 On acceptance of y[i], i<N-M: m_valid_y=0 next cycle, accumulator cleared, return to COMPUTE for i+1.
REQ-029 On acceptance of y[N-M]: go to LOAD, clear both counts; next vector requires reloading N x and M f values.
REQ-030 m_valid_y SHALL NOT assert in LOAD; exactly N-M+1 results per loaded vector.
REQ-031 s_valid with ready=0 SHALL NOT change any memory or count.

Reset
REQ-032 Reset SHALL force s_ready_x=0, s_ready_f=0, m_valid_y=0, m_data_out_y=0, state LOAD, counts 0, accumulator 0.
REQ-033 Reset in any state, including mid-COMPUTE or stalled OUTPUT, SHALL abandon the vector; no result emitted afterwards until a full reload.
REQ-034 s_ready_x and s_ready_f SHALL rise the first cycle after reset deasserts.
REQ-035 Memory contents need no reset.

Verification
REQ-036 Defaults, x=10,-20,30,-40,50,60,70,80; f=10,20,-30,40 -> y=-2800,3600,400,1600,2800, then no m_valid_y for 100 cycles.
REQ-037 Second vector back-to-back, x=-90,100,-110,120,-50,40,30,-20; f=-50,-60,70,80 -> y=400,6000,-2000,2200,600.
REQ-038 RELU=1 with REQ-036 data -> y=0,3600,400,1600,2800.
REQ-039 DW=8,OW=12: x all 127, f all 127 -> every y=2047; x all -128, f all 127 -> every y=-2048.
REQ-040 Random valid/ready toggling on all three channels, plus m_ready_y held 0 for 20 cycles in OUTPUT -> m_valid_y and data stable, results identical to REQ-036.
REQ-041 Reset asserted mid-COMPUTE of y[2] -> all outputs 0 next cycle; reload REQ-037 data -> exactly 400,6000,-2000,2200,600.
